config_chain_loader: RTL

//  Upstream driver for a tile's serial configuration chain (shift_in/cen/cset).

---
 rtl/config_chain_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/config_chain_loader.sv
// Serialises configuration words LSB-first onto a tile's shift_in/cen/cset chain.
// Define CONFIG_LOADER_READBACK_EN to capture the chain's previous contents from cfg_return.
module config_chain_loader #(
  parameter int WORD_W    = 16,
  parameter int CHAIN_LEN = 4096,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_shift,
  output logic              cfg_cen,
  output logic              cfg_cset,
  output logic              busy,
  output logic              done
`ifdef CONFIG_LOADER_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              cfg_return
`endif
);

  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SET, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]   word_bits_q, word_bits_d;
  logic              shift_q, shift_d;
  logic              in_ready_q, cen_q, cset_q, busy_q, done_q;

  // bit_cnt_q/word_bits_q count bits already placed on cfg_shift, including the one currently shown.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    word_bits_d = word_bits_q;
    shift_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          bit_cnt_d   = '0;
          word_bits_d = '0;
        end
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          state_d     = SHIFT;
          shift_d     = in_data[0];
          sr_d        = in_data >> 1;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          word_bits_d = WB_W'(1);
        end
      end
      SHIFT: begin
        if (bit_cnt_q == CNT_W'(CHAIN_LEN)) begin
          state_d = SET;
        end else if (word_bits_q == WB_W'(WORD_W)) begin
          state_d = LOAD;
        end else begin
          shift_d     = sr_q[0];
          sr_d        = sr_q >> 1;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          word_bits_d = word_bits_q + WB_W'(1);
        end
      end
      SET:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a registered decode of the next state, so it lines up with state_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      word_bits_q <= '0;
      shift_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      cen_q       <= 1'b0;
      cset_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      word_bits_q <= word_bits_d;
      shift_q     <= shift_d;
      in_ready_q  <= (state_d == LOAD);
      cen_q       <= (state_d == SHIFT);
      cset_q      <= (state_d == SET);
      busy_q      <= (state_d == LOAD) || (state_d == SHIFT) || (state_d == SET);
      done_q      <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign cfg_shift = shift_q;
  assign cfg_cen   = cen_q;
  assign cfg_cset  = cset_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CONFIG_LOADER_READBACK_EN
  localparam int REM       = CHAIN_LEN % WORD_W;
  localparam int LAST_BITS = (REM == 0) ? WORD_W : REM;

  logic [WORD_W-1:0] rb_sr_q, rb_sr_d, rb_data_q, rb_data_d, rb_cap;
  logic              rb_valid_q, rb_valid_d;

  // Returned bits enter at the MSB; a short last word is shifted down so it lands right-aligned.
  always_comb begin
    rb_cap     = {cfg_return, rb_sr_q[WORD_W-1:1]};
    rb_sr_d    = rb_sr_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (cen_q) begin
      rb_sr_d = rb_cap;
      if (bit_cnt_q == CNT_W'(CHAIN_LEN)) begin
        rb_valid_d = 1'b1;
        rb_data_d  = rb_cap >> (WORD_W - LAST_BITS);
        rb_sr_d    = '0;
      end else if (word_bits_q == WB_W'(WORD_W)) begin
        rb_valid_d = 1'b1;
        rb_data_d  = rb_cap;
        rb_sr_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rb_sr_q    <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_sr_q    <= rb_sr_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`endif

endmodule
